// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds uart_tx one byte at a time, decoupling burst producers
// from the serial line rate.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              tx_activate,
  output logic [7:0]        tx_data,
  input  logic              tx_active,
  input  logic              tx_done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitAck,
    StWaitDone,
    StWaitClr
  } state_e;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [7:0]        tx_data_q;
  logic              tx_activate_q, tx_activate_d;
  logic              overflow_q;
  logic              push, pop;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  // Exactly one byte leaves the FIFO per LOAD; IDLE only enters LOAD when non-empty.
  assign pop   = (state_q == StLoad);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_activate_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A frame started before our reset must finish before we issue another.
        if (!empty && !tx_active && !tx_done) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d       = StIssue;
        tx_activate_d = 1'b1;
      end
      StIssue: begin
        state_d       = StWaitAck;
        tx_activate_d = 1'b1;
      end
      StWaitAck: begin
        if (tx_active) begin
          state_d = StWaitDone;
        end else begin
          tx_activate_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          state_d = StWaitClr;
        end
      end
      StWaitClr: begin
        if (!tx_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tx_activate_q <= 1'b0;
      tx_data_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_activate_q <= tx_activate_d;
      overflow_q    <= wr_en && full;
      if (pop) begin
        tx_data_q <= mem[rd_ptr_q];
      end
    end
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != StIdle);
  assign tx_activate = tx_activate_q;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx (4 clocks per bit)
// and a serial-line receiver that reconstructs the transmitted bytes.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       tx_activate;
  logic [7:0] tx_data;
  logic       tx_active;
  logic       tx_done;
  logic       serial;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int frame_err = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  uart_tx_fifo #(
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .busy       (busy),
    .tx_activate(tx_activate),
    .tx_data    (tx_data),
    .tx_active  (tx_active),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural uart_tx: no reset, so a frame in progress always completes.
  initial begin
    logic [7:0] d;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    serial    = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_activate === 1'b1) begin
        d         = tx_data;
        tx_active = 1'b1;
        serial    = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          serial = d[i];
          repeat (4) @(negedge clk);
        end
        serial = 1'b1;
        repeat (4) @(negedge clk);
        tx_active = 1'b0;
        tx_done   = 1'b1;
        repeat (2) @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Receiver samples mid-bit on posedges (line changes on negedges).
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (serial === 1'b0) begin
        repeat (2) @(posedge clk);
        if (serial !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(posedge clk);
          b[i] = serial;
        end
        repeat (4) @(posedge clk);
        if (serial !== 1'b1) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_seen++;
  end

  task automatic burst(input logic [7:0] base, input int n, output int peak);
    peak = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      exp_q.push_back(wr_data);
    end
    @(negedge clk);
    if (int'(count) > peak) peak = int'(count);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(rx_q.size() >= exp_q.size() && !busy && empty && !tx_active && !tx_done)
           && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int peak;
    int n;
    logic early;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_activate", tx_activate, 0);
    check("rst_txdata", tx_data, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single byte, activate on the third edge counting the write edge
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    check("t1_count_e0", count, 1);
    check("t1_empty_e0", empty, 0);
    check("t1_act_e0", tx_activate, 0);
    @(negedge clk);
    check("t1_act_e1", tx_activate, 0);
    check("t1_busy_e1", busy, 1);
    @(negedge clk);
    check("t1_act_e2", tx_activate, 1);
    check("t1_txdata", tx_data, 8'hA5);
    check("t1_count_e2", count, 0);
    drain("t1");
    check("t1_busy_end", busy, 0);
    check("t1_empty_end", empty, 1);
    check("t1_frame", frame_err, 0);

    // 2: 16-byte burst; one pop lands mid-burst so 15 bytes peak
    burst(8'h00, 16, peak);
    check("t2_peak", peak, 15);
    drain("t2");
    check("t2_no_ovf", ovf_seen, 0);

    // 3: fill to full behind an in-flight frame, then overflow
    burst(8'h20, 17, peak);
    check("t3_full", full, 1);
    check("t3_count", count, 16);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    check("t3_ovf_pulse", overflow, 1);
    check("t3_count_ovf", count, 16);
    @(negedge clk);
    check("t3_ovf_clear", overflow, 0);
    drain("t3");
    check("t3_ovf_once", ovf_seen, 1);

    // 4: write in the LOAD cycle leaves count unchanged
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_count_e0", count, 1);
    @(negedge clk);
    check("t4_count_e1", count, 1);
    wr_en = 1'b1; wr_data = 8'hC3; exp_q.push_back(8'hC3);
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_count_load", count, 1);
    check("t4_txdata", tx_data, 8'h5A);
    drain("t4");

    // 5: 40 bytes in bursts of 10 across pointer wrap
    for (int k = 0; k < 4; k++) begin
      burst(8'h80 + 8'(k * 10), 10, peak);
      drain($sformatf("t5_%0d", k));
    end

    // 6: reset while byte 2 of 5 is on the line
    burst(8'h61, 5, peak);
    n = 0;
    while (!(rx_q.size() == 1 && tx_active) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_byte2", (n < 4000), 1);
    repeat (8) @(negedge clk);
    check("t6_queued", count, 3);
    rst = 1'b1;
    #1;
    check("t6_rst_empty", empty, 1);
    check("t6_rst_act", tx_activate, 0);
    check("t6_rst_count", count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk);
    wr_en = 1'b0;
    early = 1'b0;
    n = 0;
    while ((tx_active || tx_done) && n < 4000) begin
      if (tx_activate) early = 1'b1;
      @(negedge clk);
      n++;
    end
    check("t6_no_early_issue", early, 0);
    drain("t6");
    check("t6_frame", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
